// File: rtl/magma_pkg.sv
// Shared constants, state encoding, S-boxes and round-key schedule for the Magma engine.
package magma_pkg;

    localparam int ROUNDS  = 32;
    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // SBOX[i][v] substitutes nibble i (bits 4i+3:4i) of value v.
    localparam logic [3:0] SBOX [8][16] = '{
        '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
        '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
        '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
        '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
        '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
        '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
        '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
        '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
    };

    // Keys run forward (K1..K8 repeated) until the limit, then backward K8..K1.
    function automatic logic [2:0] key_idx(input logic [4:0] round, input logic decrypt);
        logic [4:0] fwd_limit;
        fwd_limit = decrypt ? 5'd8 : 5'd24;
        return (round < fwd_limit) ? round[2:0] : ~round[2:0];
    endfunction

endpackage

// File: rtl/magma_round.sv
// One combinational Magma Feistel round; the last round skips the half swap.
module magma_round
    import magma_pkg::*;
(
    input  logic [31:0] a1,
    input  logic [31:0] a0,
    input  logic [31:0] k,
    input  logic        last,
    output logic [31:0] a1_n,
    output logic [31:0] a0_n
);

    logic [31:0] t;
    logic [31:0] s;
    logic [31:0] g;

    always_comb begin
        t = a0 + k;
        for (int i = 0; i < 8; i++) begin
            s[4*i +: 4] = SBOX[i][t[4*i +: 4]];
        end
        g = {s[20:0], s[31:21]};
        if (last) begin
            a1_n = g ^ a1;
            a0_n = a0;
        end else begin
            a1_n = a0;
            a0_n = g ^ a1;
        end
    end

endmodule

// File: rtl/magma_core.sv
// Magma block engine, RPC rounds per clock, valid/ready on both sides.
// Optional MAGMA_KEY_ZEROIZE_EN clears key and state on the output handshake.
module magma_core
    import magma_pkg::*;
#(
    parameter int RPC     = 1,
    parameter int OUT_REG = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               decrypt,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic [KEY_W-1:0]   key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] data_out,
    output logic               busy
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
        $error("magma_core: RPC must be 1, 2, 4 or 8");
    end

    state_t           state_q, state_d;
    logic [31:0]      a1_q, a0_q;
    logic [KEY_W-1:0] key_q;
    logic             dec_q;
    logic [5:0]       cnt_q, cnt_nxt;
    logic             last_step;
    logic             accept;
    logic [31:0]      a1_run, a0_run;

    assign cnt_nxt   = cnt_q + 6'(RPC);
    assign last_step = (cnt_nxt == 6'(ROUNDS));

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output gets a default first so no branch can infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = !reset;
                accept   = in_valid;
                if (in_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_step) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Round chain: stage j handles round cnt_q + j within the same cycle.
    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        logic [31:0] a1_i, a0_i, a1_o, a0_o, rk;
        logic [4:0]  r;
        logic [2:0]  idx;
        if (j == 0) begin : g_first
            assign a1_i = a1_q;
            assign a0_i = a0_q;
        end else begin : g_next
            assign a1_i = g_rnd[j-1].a1_o;
            assign a0_i = g_rnd[j-1].a0_o;
        end
        assign r   = cnt_q[4:0] + 5'(j);
        assign idx = key_idx(r, dec_q);
        assign rk  = key_q[32*(7-int'(idx)) +: 32];
        magma_round u_round (
            .a1   (a1_i),
            .a0   (a0_i),
            .k    (rk),
            .last (r == 5'd31),
            .a1_n (a1_o),
            .a0_n (a0_o)
        );
    end

    assign a1_run = g_rnd[RPC-1].a1_o;
    assign a0_run = g_rnd[RPC-1].a0_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a1_q  <= '0;
            a0_q  <= '0;
            key_q <= '0;
            dec_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            a1_q  <= data_in[63:32];
            a0_q  <= data_in[31:0];
            key_q <= key;
            dec_q <= decrypt;
            cnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            a1_q  <= a1_run;
            a0_q  <= a0_run;
            cnt_q <= cnt_nxt;
`ifdef MAGMA_KEY_ZEROIZE_EN
        end else if (state_q == ST_DONE && out_ready) begin
            a1_q  <= '0;
            a0_q  <= '0;
            key_q <= '0;
`endif
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [BLOCK_W-1:0] dout_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dout_q <= '0;
            end else if (state_q == ST_RUN && last_step) begin
                dout_q <= {a1_run, a0_run};
`ifdef MAGMA_KEY_ZEROIZE_EN
            end else if (state_q == ST_DONE && out_ready) begin
                dout_q <= '0;
`endif
            end
        end
        assign data_out = dout_q;
    end else begin : g_out_comb
        assign data_out = {a1_q, a0_q};
    end

endmodule

// File: tb/tb_magma_core.sv
// Four magma_core lanes (RPC 1/2/4/8, lane 2 unregistered output) share stimulus;
// results are scored against known answers and an independent Magma model.
module tb_magma_core;

    localparam int NL = 4;
    localparam logic [255:0] KAT_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0]  KAT_PT  = 64'hfedcba9876543210;
    localparam logic [63:0]  KAT_CT  = 64'h4ee901e5c2d8ca3d;

    // Each word lists pi_i entries 0..15 from the most significant nibble down.
    localparam logic [63:0] PI [8] = '{
        64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F, 64'hB3582FADE174C960, 64'hC821D4F670A53E9B,
        64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0, 64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
    };

    typedef struct {
        logic [255:0] key;
        logic [63:0]  din;
        logic         dec;
        logic [63:0]  exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset, in_valid, decrypt, out_ready;
    logic [63:0]   data_in;
    logic [255:0]  key;
    logic [NL-1:0] in_ready_v, out_valid_v, busy_v;
    logic [63:0]   dout_v [NL];

    int            n_chk = 0;
    int            n_pass = 0;
    logic [63:0]   sb_q[$];
    vec_t          vecs [6];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        magma_core #(.RPC(1 << g), .OUT_REG(g == 2 ? 0 : 1)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .decrypt   (decrypt),
            .data_in   (data_in),
            .key       (key),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .data_out  (dout_v[g]),
            .busy      (busy_v[g])
        );
    end

    function automatic logic [31:0] ref_g(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] t, s;
        logic [63:0] p;
        t = a + k;
        for (int i = 0; i < 8; i++) begin
            p = PI[i];
            s[4*i +: 4] = p[60 - 4*int'(t[4*i +: 4]) +: 4];
        end
        return {s[20:0], s[31:21]};
    endfunction

    // Decryption uses the encryption schedule reversed.
    function automatic logic [63:0] ref_magma(input logic [63:0] blk, input logic [255:0] k, input logic dec);
        logic [31:0] kw [8];
        logic [31:0] enc_ks [32];
        logic [31:0] a1, a0, tmp;
        for (int i = 0; i < 8; i++) kw[i] = k[255 - 32*i -: 32];
        for (int i = 0; i < 32; i++) enc_ks[i] = (i < 24) ? kw[i % 8] : kw[7 - i % 8];
        a1 = blk[63:32];
        a0 = blk[31:0];
        for (int r = 0; r < 32; r++) begin
            tmp = ref_g(a0, dec ? enc_ks[31 - r] : enc_ks[r]) ^ a1;
            a1  = a0;
            a0  = tmp;
        end
        return {a0, a1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_outputs_check(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready_v), 64'h0);
        check({tag, "_out_valid"}, 64'(out_valid_v), 64'h0);
        check({tag, "_busy"}, 64'(busy_v), 64'h0);
        for (int i = 0; i < NL; i++) check($sformatf("%s_dout%0d", tag, i), dout_v[i], 64'h0);
    endtask

    // One block through all lanes; optional in_valid pulse in RUN and a back-pressure hold.
    task automatic do_block(input logic [63:0] din, input logic [255:0] k, input logic dec,
                            input logic [63:0] exp, input int pulse_at, input int hold, input string tag);
        int          lat [NL];
        logic        all_seen, bp_bad;
        logic [63:0] want;
        for (int i = 0; i < NL; i++) lat[i] = 0;
        sb_q.push_back(exp);
        data_in  = din;
        key      = k;
        decrypt  = dec;
        in_valid = 1'b1;
        check({tag, "_accept_ready"}, 64'(in_ready_v), 64'hF);
        tick();
        in_valid = 1'b0;
        data_in  = ~din;
        key      = ~k;
        decrypt  = ~dec;
        for (int c = 1; c <= 64; c++) begin
            all_seen = 1'b1;
            for (int i = 0; i < NL; i++) begin
                if (lat[i] == 0 && out_valid_v[i]) lat[i] = c;
                if (lat[i] == 0) all_seen = 1'b0;
            end
            if (all_seen) break;
            in_valid = (c == pulse_at);
            if (c == pulse_at) data_in = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        want = sb_q.pop_front();
        for (int i = 0; i < NL; i++) begin
            check($sformatf("%s_lat%0d", tag, i), 64'(lat[i]), 64'(32 / (1 << i) + 1));
            check($sformatf("%s_data%0d", tag, i), dout_v[i], want);
        end
        if (hold > 0) begin
            bp_bad   = 1'b0;
            in_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                data_in = {$urandom, $urandom};
                tick();
                for (int i = 0; i < NL; i++)
                    if (!out_valid_v[i] || in_ready_v[i] || dout_v[i] !== want) bp_bad = 1'b1;
            end
            in_valid = 1'b0;
            check({tag, "_backpressure"}, 64'(bp_bad), 64'h0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"}, {56'h0, out_valid_v, busy_v}, 64'h0);
    endtask

    initial begin
        int   first [NL];
        int   second [NL];
        logic ov0;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        decrypt   = 1'b0;
        data_in   = '0;
        key       = '0;
        #2;
        reset_outputs_check("por");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("por_ready_after", 64'(in_ready_v), 64'hF);

        vecs[0] = '{KAT_KEY, KAT_PT, 1'b0, KAT_CT};
        vecs[1] = '{KAT_KEY, KAT_CT, 1'b1, KAT_PT};
        for (int v = 2; v < 6; v++) begin
            vecs[v].key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            vecs[v].din = {$urandom, $urandom};
            vecs[v].dec = v[0];
            vecs[v].exp = ref_magma(vecs[v].din, vecs[v].key, vecs[v].dec);
        end
        for (int v = 0; v < 6; v++)
            do_block(vecs[v].din, vecs[v].key, vecs[v].dec, vecs[v].exp, 0, 0, $sformatf("vec%0d", v));

        do_block(KAT_PT, KAT_KEY, 1'b0, KAT_CT, 2, 10, "bp");

        // Continuous requests with out_ready held: spacing of acceptances per lane.
        for (int i = 0; i < NL; i++) begin
            first[i]  = -1;
            second[i] = -1;
        end
        data_in   = KAT_PT;
        key       = KAT_KEY;
        decrypt   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < NL; i++) begin
                if (in_ready_v[i]) begin
                    if (first[i] < 0) first[i] = c;
                    else if (second[i] < 0) second[i] = c;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < NL; i++)
            check($sformatf("thru_period%0d", i), 64'(second[i] - first[i]), 64'(32 / (1 << i) + 2));
        for (int c = 0; c < 50 && busy_v != '0; c++) tick();
        check("thru_drain", 64'(busy_v), 64'h0);
        out_ready = 1'b0;

        // Abort lane 0 with its round counter at 12.
        data_in  = KAT_PT;
        key      = KAT_KEY;
        decrypt  = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ov0 = 1'b0;
        repeat (12) begin
            ov0 |= out_valid_v[0];
            tick();
        end
        reset = 1'b1;
        #1;
        reset_outputs_check("mid");
        repeat (3) begin
            @(posedge clk);
            #1 ov0 |= out_valid_v[0];
        end
        reset = 1'b0;
        #1;
        check("mid_ready_after", 64'(in_ready_v), 64'hF);
        repeat (40) begin
            ov0 |= out_valid_v[0];
            tick();
        end
        check("mid_no_output", 64'(ov0), 64'h0);
        do_block(KAT_CT, KAT_KEY, 1'b1, KAT_PT, 0, 0, "post_rst");

        do_block(KAT_PT, KAT_KEY, 1'b0, KAT_CT, 0, 0, "zero");
        for (int i = 0; i < NL; i++) begin
`ifdef MAGMA_KEY_ZEROIZE_EN
            check($sformatf("zeroize_dout%0d", i), dout_v[i], 64'h0);
`else
            check($sformatf("retain_dout%0d", i), dout_v[i], KAT_CT);
`endif
        end

        check("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
